// File: rtl/calc_pkg.sv
// Shared types for the calculator scheduler.
//   op_e          : calculator opcodes; 000 and 111 are reserved/invalid.
//   sched_state_e : scheduler FSM states.
//   is_valid_op() : true for opcodes the core can execute.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_INV0 = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_DIV  = 3'b100,
    OP_SQRT = 3'b101,
    OP_GCD  = 3'b110,
    OP_INV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op != OP_INV0) && (op != OP_INV7);
  endfunction

endpackage

// File: rtl/calc_sched_if.sv
// Bundle of requester-side and core-side signals of calc_sched.
//   req_*      : per-requester request bus (slices of 3 / DATA_WIDTH bits per requester)
//   rsp_*      : one-hot response strobe plus shared result/error
//   core_*     : calculator core pin interface
//   busy       : scheduler not idle
// Modports: master = the scheduler, slave = requesters plus core.
interface calc_sched_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [3*NUM_REQ-1:0]          req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_opa;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_opb;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_result;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         core_opa;
  logic [DATA_WIDTH-1:0]         core_opb;
  logic [2:0]                    core_op;
  logic                          core_start;
  logic                          core_ready;
  logic                          core_done;
  logic [DATA_WIDTH-1:0]         core_result;
  logic                          busy;

  modport master (
    input  req_valid, req_op, req_opa, req_opb, core_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, core_opa, core_opb, core_op,
           core_start, busy
  );

  modport slave (
    output req_valid, req_op, req_opa, req_opb, core_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, core_opa, core_opb, core_op,
           core_start, busy
  );

endinterface

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin search.
//   req_i     : request vector
//   ptr_i     : index to start searching from (highest priority)
//   gnt_o     : first requesting index at or after ptr_i, wrapping mod NUM_REQ
//   any_req_o : at least one request is set (gnt_o only meaningful when high)
module calc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] gnt_o,
  output logic                       any_req_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    logic [IdxW:0] sum;
    gnt_o     = ptr_i;
    any_req_o = 1'b0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One extra bit so ptr + i cannot overflow before the wrap.
      sum = {1'b0, ptr_i} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(NUM_REQ)) begin
        sum = sum - (IdxW+1)'(NUM_REQ);
      end
      if (!any_req_o && req_i[sum[IdxW-1:0]]) begin
        any_req_o = 1'b1;
        gnt_o     = sum[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/calc_sched.sv
// Round-robin scheduler sharing one calculator core between NUM_REQ requesters.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : calc_sched_if.master (request/response bus and core pins)
// Invalid opcodes are answered directly with err=1/result=0; a core that never
// signals done is abandoned after TIMEOUT_CYCLES cycles in WAIT (0 = no timeout).
module calc_sched
  import calc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          rst,
  calc_sched_if.master bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  sched_state_e          state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       gnt_q, gnt_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  inv_q, inv_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic [IdxW-1:0]       arb_gnt;
  logic                  any_req;

  logic [2:0]            op_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] opa_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] opb_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign op_arr[g]  = bus.req_op[3*g +: 3];
    assign opa_arr[g] = bus.req_opa[DATA_WIDTH*g +: DATA_WIDTH];
    assign opb_arr[g] = bus.req_opb[DATA_WIDTH*g +: DATA_WIDTH];
  end

  calc_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.core_ready && any_req) begin
          gnt_d = arb_gnt;
          op_d  = op_arr[arb_gnt];
          opa_d = opa_arr[arb_gnt];
          opb_d = opb_arr[arb_gnt];
          if (is_valid_op(op_d)) begin
            inv_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            // Answer locally; the core is never started.
            inv_d    = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
            state_d  = RESP;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          // Done wins over a simultaneous timeout.
          result_d = bus.core_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYCLES > 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.core_start = 1'b0;
    if (state_q == ISSUE) begin
      bus.core_start     = 1'b1;
      bus.req_ready[gnt_q] = 1'b1;
    end
    if (state_q == RESP) begin
      bus.rsp_valid[gnt_q] = 1'b1;
      // Invalid ops never passed through ISSUE, so acknowledge them here.
      if (inv_q) begin
        bus.req_ready[gnt_q] = 1'b1;
      end
    end
  end

  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.core_opa   = opa_q;
  assign bus.core_opb   = opb_q;
  assign bus.core_op    = op_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_calc_sched.sv
// Scoreboard bench for calc_sched: stimulus pushes expected core starts and
// responses into queues; the core model and a response monitor pop and compare.
module tb_calc_sched;
  import calc_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  calc_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  calc_sched #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [31:0] result;
    logic        err;
    bit          inv;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          idx;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    int          cyc;
  } start_t;

  rsp_t   exp_rsp[$];
  start_t exp_start[$];

  // Core model / requester agent state
  int          lat = 1;
  bit          no_done = 1'b0;
  bit          hold_nr = 1'b0;
  int          stray_cyc = -1;
  int          cnt = 0;
  logic [31:0] cres = '0;
  logic [31:0] copa = '0;
  logic [31:0] copb = '0;
  int          rep [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] core_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a * b;
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int r);
    bus.req_op[3*i +: 3]    = op;
    bus.req_opa[32*i +: 32] = a;
    bus.req_opb[32*i +: 32] = b;
    rep[i]                  = r;
    bus.req_valid[i]        = 1'b1;
  endtask

  task automatic push_start(input int i, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int c);
    start_t s;
    s.idx = i; s.op = op; s.opa = a; s.opb = b; s.cyc = c;
    exp_start.push_back(s);
  endtask

  task automatic push_rsp(input int i, input logic [31:0] res, input logic err, input bit inv,
                          input int c);
    rsp_t e;
    e.idx = i; e.result = res; e.err = err; e.inv = inv; e.cyc = c;
    exp_rsp.push_back(e);
  endtask

  // One cycle: requester agent, then core model, all at the falling edge.
  task automatic tick();
    start_t s;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i]) begin
        if (rep[i] > 0) rep[i]--;
        else bus.req_valid[i] = 1'b0;
      end
    end
    bus.core_done = 1'b0;
    if (rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !no_done) begin
          chk("core_opa_held", bus.core_opa, copa);
          chk("core_opb_held", bus.core_opb, copb);
          bus.core_done   = 1'b1;
          bus.core_result = cres;
        end
      end
      if (bus.core_start) begin
        if (exp_start.size() == 0) begin
          chk("unexpected_start", bus.core_start, 0);
        end else begin
          s = exp_start.pop_front();
          chk("start_op", bus.core_op, s.op);
          chk("start_opa", bus.core_opa, s.opa);
          chk("start_opb", bus.core_opb, s.opb);
          chk("start_ready", bus.req_ready, 64'(1) << s.idx);
          if (s.cyc >= 0) chk("start_cycle", cyc, s.cyc);
        end
        cnt  = lat;
        copa = bus.core_opa;
        copb = bus.core_opb;
        cres = core_calc(bus.core_op, bus.core_opa, bus.core_opb);
      end
      if (cyc == stray_cyc) begin
        bus.core_done   = 1'b1;
        bus.core_result = 32'hBAD0_BAD0;
      end
    end
    bus.core_ready = (cnt == 0) && !hold_nr;
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", bus.rsp_valid, 0);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_valid", bus.rsp_valid, 64'(1) << e.idx);
          chk("rsp_result", bus.rsp_result, e.result);
          chk("rsp_err", bus.rsp_err, e.err);
          if (e.inv) chk("inv_ready", bus.req_ready, 64'(1) << e.idx);
          if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
        end
      end else if (bus.req_ready != '0 && !bus.core_start) begin
        chk("spurious_ready", bus.req_ready, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  fop [NR] = '{3'b001, 3'b010, 3'b011, 3'b001};
  logic [31:0] fa  [NR] = '{32'd10, 32'd100, 32'd6, 32'hFFFF_FFFF};
  logic [31:0] fb  [NR] = '{32'd20, 32'd1, 32'd7, 32'd2};
  logic [31:0] fr  [NR] = '{32'd30, 32'd99, 32'd42, 32'd1};
  int          ord [6]  = '{0, 1, 2, 3, 0, 1};
  int          ord2 [4] = '{2, 3, 0, 1};

  initial begin : stim
    int c;
    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_opa     = '0;
    bus.req_opb     = '0;
    bus.core_ready  = 1'b1;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    for (int i = 0; i < NR; i++) rep[i] = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    tick();

    // Single ADD, L=4: start at T+1, response at T+6
    c = cyc; lat = 4;
    set_req(0, OP_ADD, 32'd5, 32'd3, 0);
    push_start(0, OP_ADD, 32'd5, 32'd3, c + 1);
    push_rsp(0, 32'd8, 1'b0, 1'b0, c + 6);
    repeat (10) tick();

    // SUB on req3 (moves ptr back to 0), L=1
    c = cyc; lat = 1;
    set_req(3, OP_SUB, 32'd9, 32'd4, 0);
    push_start(3, OP_SUB, 32'd9, 32'd4, c + 1);
    push_rsp(3, 32'd5, 1'b0, 1'b0, c + 3);
    repeat (6) tick();

    // Fairness: all four held, req0/req1 re-request once -> 0,1,2,3,0,1
    c = cyc;
    for (int i = 0; i < NR; i++) set_req(i, fop[i], fa[i], fb[i], (i < 2) ? 1 : 0);
    for (int k = 0; k < 6; k++) begin
      push_start(ord[k], fop[ord[k]], fa[ord[k]], fb[ord[k]], c + 4*k + 1);
      push_rsp(ord[k], fr[ord[k]], 1'b0, 1'b0, c + 4*k + 3);
    end
    repeat (28) tick();

    // ptr now 2 -> 2,3,0,1
    c = cyc;
    for (int i = 0; i < NR; i++) set_req(i, fop[i], fa[i], fb[i], 0);
    for (int k = 0; k < 4; k++) begin
      push_start(ord2[k], fop[ord2[k]], fa[ord2[k]], fb[ord2[k]], c + 4*k + 1);
      push_rsp(ord2[k], fr[ord2[k]], 1'b0, 1'b0, c + 4*k + 3);
    end
    repeat (20) tick();

    // Invalid opcodes: ready and response together at T+1, no core start
    c = cyc;
    set_req(2, OP_INV7, 32'h55, 32'h66, 0);
    push_rsp(2, 32'd0, 1'b1, 1'b1, c + 1);
    repeat (4) tick();
    c = cyc;
    set_req(2, OP_INV0, 32'h77, 32'h88, 0);
    push_rsp(2, 32'd0, 1'b1, 1'b1, c + 1);
    repeat (4) tick();

    // Timeout: 16 WAIT cycles then err; later stray done ignored
    c = cyc; lat = 20; no_done = 1'b1;
    set_req(2, OP_SUB, 32'd50, 32'd8, 0);
    push_start(2, OP_SUB, 32'd50, 32'd8, c + 1);
    push_rsp(2, 32'd0, 1'b1, 1'b0, c + 18);
    stray_cyc = c + 24;
    repeat (30) tick();
    no_done = 1'b0; stray_cyc = -1;

    // Done on the 16th WAIT cycle wins over the timeout
    c = cyc; lat = 16;
    set_req(2, OP_MUL, 32'd3, 32'd4, 0);
    push_start(2, OP_MUL, 32'd3, 32'd4, c + 1);
    push_rsp(2, 32'd12, 1'b0, 1'b0, c + 18);
    repeat (22) tick();

    // Reset mid-WAIT: request abandoned, ptr back to 0
    c = cyc; lat = 10;
    set_req(3, OP_ADD, 32'd1, 32'd1, 0);
    push_start(3, OP_ADD, 32'd1, 32'd1, c + 1);
    repeat (4) tick();
    rst = 1'b1;
    bus.req_valid[3] = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_core_start", bus.core_start, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_rsp_result", bus.rsp_result, 0);
    chk("mid_rst_rsp_err", bus.rsp_err, 0);
    chk("mid_rst_core_op", bus.core_op, 0);
    chk("mid_rst_core_opa", bus.core_opa, 0);
    chk("mid_rst_core_opb", bus.core_opb, 0);
    c = cyc; lat = 2;
    set_req(1, OP_SUB, 32'd7, 32'd2, 0);
    set_req(3, OP_ADD, 32'd2, 32'd2, 0);
    push_start(1, OP_SUB, 32'd7, 32'd2, c + 1);
    push_rsp(1, 32'd5, 1'b0, 1'b0, c + 4);
    push_start(3, OP_ADD, 32'd2, 32'd2, c + 6);
    push_rsp(3, 32'd4, 1'b0, 1'b0, c + 9);
    repeat (14) tick();

    // core_ready gating; operands changed before acceptance are used
    hold_nr = 1'b1; bus.core_ready = 1'b0; lat = 3;
    set_req(3, OP_ADD, 32'h100, 32'h23, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("gated_ready", bus.req_ready, 0);
      chk("gated_start", bus.core_start, 0);
      if (k == 4) bus.req_opa[32*3 +: 32] = 32'h1000;
    end
    c = cyc;
    hold_nr = 1'b0; bus.core_ready = 1'b1;
    push_start(3, OP_ADD, 32'h1000, 32'h23, c + 1);
    push_rsp(3, 32'h1023, 1'b0, 1'b0, c + 5);
    tick();
    bus.req_opa[32*3 +: 32] = 32'hDEAD;
    repeat (10) tick();

    for (int k = 0; k < 200 && (exp_rsp.size() > 0 || exp_start.size() > 0); k++) tick();
    chk("pending_rsp", exp_rsp.size(), 0);
    chk("pending_start", exp_start.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
